// File: rtl/i2c_cfg_seq.sv
// Table-driven I2C register-configuration sequencer: walks REG_NUM ROM words and
// issues one I2C write per entry. Optional macro CFG_RETRY_EN enables per-entry retry.
module i2c_cfg_seq #(
  parameter int REG_NUM   = 19,
  parameter int IDX_W     = 5,
  parameter int DATA_W    = 16,
  parameter int DLY_CYC   = 255,
  parameter int TMO_CYC   = 4095,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_word,
  output logic              i2c_exec,
  output logic [DATA_W-1:0] i2c_data,
  input  logic              i2c_done,
  input  logic              i2c_err,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [IDX_W-1:0]  err_idx
);

  typedef enum logic [2:0] {PWR, LOAD, EXEC, WAIT, DONE, ERR} state_t;

  localparam int DLY_W = $clog2(DLY_CYC + 2);
  localparam int TMO_W = $clog2(TMO_CYC + 2);

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [DLY_W-1:0]   dly_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [DATA_W-1:0]  data_q;
  logic               dly_hit, tmo_hit, last_idx, good_done, err_evt;

`ifdef CFG_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  logic [RTY_W-1:0]   rty_cnt, rty_d;
`endif

  assign dly_hit   = (int'(dly_cnt) + 1) >= DLY_CYC;
  assign tmo_hit   = (int'(tmo_cnt) + 1) >= TMO_CYC;
  assign last_idx  = int'(idx) == (REG_NUM - 1);
  assign good_done = i2c_done & ~i2c_err;
  // A completion in the timeout cycle takes priority over the timeout
  assign err_evt   = (i2c_done & i2c_err) | (~i2c_done & tmo_hit);

  assign cfg_idx  = idx;
  assign i2c_exec = (state == EXEC);
  // The ROM word is forwarded during EXEC so data is valid alongside the pulse
  assign i2c_data = (state == EXEC) ? cfg_word : data_q;

  always_comb begin
    state_d = state;
    idx_d   = idx;
`ifdef CFG_RETRY_EN
    rty_d   = rty_cnt;
`endif
    case (state)
      PWR: begin
        if (dly_hit) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: state_d = EXEC;
      EXEC: state_d = WAIT;
      WAIT: begin
        if (good_done) begin
          if (last_idx) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            idx_d   = idx + 1'b1;
`ifdef CFG_RETRY_EN
            rty_d   = '0;
`endif
          end
        end else if (err_evt) begin
`ifdef CFG_RETRY_EN
          if (int'(rty_cnt) < MAX_RETRY) begin
            state_d = LOAD;
            rty_d   = rty_cnt + 1'b1;
          end else begin
            state_d = ERR;
          end
`else
          state_d = ERR;
`endif
        end
      end
      DONE, ERR: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
`ifdef CFG_RETRY_EN
          rty_d   = '0;
`endif
        end
      end
      default: state_d = PWR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PWR;
      idx      <= '0;
      dly_cnt  <= '0;
      tmo_cnt  <= '0;
      data_q   <= '0;
      busy     <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      err_idx  <= '0;
`ifdef CFG_RETRY_EN
      rty_cnt  <= '0;
`endif
    end else begin
      state <= state_d;
      idx   <= idx_d;
`ifdef CFG_RETRY_EN
      rty_cnt <= rty_d;
`endif
      if (state == PWR) dly_cnt <= dly_cnt + 1'b1;
      if (state == EXEC) begin
        tmo_cnt <= '0;
        data_q  <= cfg_word;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      // Status flags follow the next state so they line up with DONE/ERR entry
      busy     <= (state_d != DONE) && (state_d != ERR);
      cfg_done <= (state_d == DONE);
      cfg_err  <= (state_d == ERR);
      if (state == WAIT && state_d == ERR)
        err_idx <= idx;
      else if ((state == DONE || state == ERR) && start)
        err_idx <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Self-checking bench for i2c_cfg_seq: table of error/timeout scenarios plus
// hand-written sequences for start timing, re-run, timeout boundary and reset abort.
module tb_i2c_cfg_seq;

  localparam int REG_NUM = 4;
  localparam int IDX_W   = 5;
  localparam int DATA_W  = 16;
  localparam int DLY_CYC = 8;
  localparam int TMO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  cfg_idx;
  logic [DATA_W-1:0] cfg_word = '0;
  logic              i2c_exec;
  logic [DATA_W-1:0] i2c_data;
  logic              i2c_done = 1'b0;
  logic              i2c_err = 1'b0;
  logic              busy, cfg_done, cfg_err;
  logic [IDX_W-1:0]  err_idx;

  i2c_cfg_seq #(
    .REG_NUM(REG_NUM), .IDX_W(IDX_W), .DATA_W(DATA_W),
    .DLY_CYC(DLY_CYC), .TMO_CYC(TMO_CYC), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_idx(cfg_idx), .cfg_word(cfg_word),
    .i2c_exec(i2c_exec), .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_err(i2c_err),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  // Synchronous register ROM: word valid one cycle after the index changes
  always @(posedge clk) cfg_word <= 16'hA000 + 16'(cfg_idx);

  typedef struct {
    string name;
    int    err_at;
    int    err_cnt;
    int    hold_at;
    int    exp_done;
    int    exp_err;
    int    exp_err_idx;
    int    exp_writes;
  } vec_t;

  int tests = 0;
  int failed = 0;

  int err_at = -1, err_cnt = 0, hold_at = -1;
  int cyc = 0;
  int pend = 0;
  logic pend_err = 1'b0;
  int att [8];
  int exec_cyc[$];
  int exec_data[$];

  // Cycle counter, exec logger and I2C slave responder; all act at the falling edge
  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
    if (rst) begin
      cyc  = 0;
      pend = 0;
      exec_cyc.delete();
      exec_data.delete();
      for (int i = 0; i < 8; i++) att[i] = 0;
    end else begin
      cyc = cyc + 1;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          i2c_done = 1'b1;
          i2c_err  = pend_err;
        end
      end
      if (i2c_exec) begin
        exec_cyc.push_back(cyc);
        exec_data.push_back(int'(i2c_data));
        if (int'(cfg_idx) < 8) att[int'(cfg_idx)] = att[int'(cfg_idx)] + 1;
        if (int'(cfg_idx) == hold_at) begin
          pend = 0;
        end else begin
          pend     = 5;
          pend_err = (int'(cfg_idx) == err_at) && (int'(cfg_idx) < 8) &&
                     (att[int'(cfg_idx)] <= err_cnt);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic tick_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      tick();
      guard++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int get_cyc(input int i);
    return (i < exec_cyc.size()) ? exec_cyc[i] : -1;
  endfunction

  function automatic int get_data(input int i);
    return (i < exec_data.size()) ? exec_data[i] : -1;
  endfunction

  task automatic run_to_end(input string name, input int budget);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < budget) begin
      tick();
      n++;
    end
    if (!(cfg_done || cfg_err)) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s end: no cfg_done/cfg_err within %0d cycles", name, budget);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int last;
    err_at  = v.err_at;
    err_cnt = v.err_cnt;
    hold_at = v.hold_at;
    do_reset();
    run_to_end(v.name, 500);
    repeat (20) tick();
    last = v.exp_done ? (REG_NUM - 1) : v.exp_err_idx;
    checkOutput({v.name, " cfg_done"}, int'(cfg_done), v.exp_done);
    checkOutput({v.name, " cfg_err"}, int'(cfg_err), v.exp_err);
    checkOutput({v.name, " err_idx"}, int'(err_idx), v.exp_err_idx);
    checkOutput({v.name, " writes"}, exec_cyc.size(), v.exp_writes);
    checkOutput({v.name, " last data"}, get_data(exec_data.size() - 1), 32'hA000 + last);
    checkOutput({v.name, " busy"}, int'(busy), 0);
  endtask

  vec_t vecs [5];

  initial begin
    int s, base;

`ifdef CFG_RETRY_EN
    vecs[0] = '{"clean",      -1,  0, -1, 1, 0, 0, 4};
    vecs[1] = '{"nack1x1",     1,  1, -1, 1, 0, 0, 5};
    vecs[2] = '{"nack2x2",     2,  2, -1, 1, 0, 0, 6};
    vecs[3] = '{"timeout0",   -1,  0,  0, 0, 1, 0, 4};
    vecs[4] = '{"nack3stuck",  3, 99, -1, 0, 1, 3, 7};
`else
    vecs[0] = '{"clean",      -1,  0, -1, 1, 0, 0, 4};
    vecs[1] = '{"nack1x1",     1,  1, -1, 0, 1, 1, 2};
    vecs[2] = '{"nack2x2",     2,  2, -1, 0, 1, 2, 3};
    vecs[3] = '{"timeout0",   -1,  0,  0, 0, 1, 0, 1};
    vecs[4] = '{"nack3stuck",  3, 99, -1, 0, 1, 3, 4};
`endif

    // Reset values, power-up delay and first-write timing
    err_at = -1; err_cnt = 0; hold_at = -1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst i2c_exec", int'(i2c_exec), 0);
    checkOutput("rst cfg_done", int'(cfg_done), 0);
    checkOutput("rst cfg_idx", int'(cfg_idx), 0);
    do_reset();
    tick_to(3);
    checkOutput("pwr busy", int'(busy), 1);
    checkOutput("pwr no exec", exec_cyc.size(), 0);
    tick_to(36);
    checkOutput("exec0 cycle", get_cyc(0), 10);
    checkOutput("exec1 cycle", get_cyc(1), 17);
    checkOutput("exec3 cycle", get_cyc(3), 31);
    for (int k = 0; k < REG_NUM; k++)
      checkOutput($sformatf("data%0d", k), get_data(k), 32'hA000 + k);
    checkOutput("cfg_done before last", int'(cfg_done), 0);
    tick_to(37);
    checkOutput("cfg_done after last", int'(cfg_done), 1);
    checkOutput("busy in done", int'(busy), 0);

    // Re-run from DONE without power-up delay; start during WAIT is ignored
    repeat (3) tick();
    base = exec_cyc.size();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("rerun cfg_done cleared", int'(cfg_done), 0);
    checkOutput("rerun busy", int'(busy), 1);
    tick();
    checkOutput("rerun first exec", get_cyc(base), s + 2);
    tick_to(s + 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_end("rerun", 200);
    repeat (10) tick();
    checkOutput("rerun writes", exec_cyc.size() - base, REG_NUM);
    for (int k = 0; k < REG_NUM; k++)
      checkOutput($sformatf("rerun data%0d", k), get_data(base + k), 32'hA000 + k);
    checkOutput("rerun cfg_done", int'(cfg_done), 1);

    // Timeout boundary: error event in the TMO_CYC-th WAIT cycle
    hold_at = 0;
    do_reset();
`ifdef CFG_RETRY_EN
    tick_to(28);
    checkOutput("tmo retry exec", get_cyc(1), 28);
    checkOutput("tmo retry no err", int'(cfg_err), 0);
`else
    tick_to(26);
    checkOutput("tmo cfg_err early", int'(cfg_err), 0);
    tick_to(27);
    checkOutput("tmo cfg_err", int'(cfg_err), 1);
    checkOutput("tmo err_idx", int'(err_idx), 0);
`endif

    // Reset while waiting on entry 2 aborts at once and restarts with full delay
    hold_at = -1;
    do_reset();
    tick_to(26);
    checkOutput("pre-abort cfg_idx", int'(cfg_idx), 2);
    rst = 1'b1;
    #1;
    checkOutput("abort cfg_idx", int'(cfg_idx), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort i2c_data", int'(i2c_data), 0);
    checkOutput("abort err flags", int'({cfg_done, cfg_err, i2c_exec}), 0);
    do_reset();
    tick_to(11);
    checkOutput("restart exec cycle", get_cyc(0), 10);
    checkOutput("restart data", get_data(0), 32'hA000);

    // Table of completion/error scenarios
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
